// File: rtl/fetch_pc_unit_pkg.sv
// Fetch PC unit shared definitions.
// Holds FSM encoding, PC width, reset vector default and an alignment helper.
package fetch_pc_unit_pkg;

   localparam int PC_WIDTH = 32;

   localparam logic [PC_WIDTH-1:0] RESET_VECTOR_DEF = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HALT  = 2'd2
   } fetch_state_e;

   function automatic logic is_word_aligned(input logic [PC_WIDTH-1:0] a);
      return (a[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Instruction memory request handshake between fetch and imem.
// Ports: imemReq/imemAddr (fetch -> mem), imemReady (mem -> fetch).
interface fetch_pc_unit_if;
   import fetch_pc_unit_pkg::*;

   logic                imemReq;
   logic [PC_WIDTH-1:0] imemAddr;
   logic                imemReady;

   modport master (
      output imemReq,
      output imemAddr,
      input  imemReady
   );

   modport slave (
      input  imemReq,
      input  imemAddr,
      output imemReady
   );

endinterface

// File: rtl/fetch_pc_unit_next_pc_mux.sv
// Next-PC priority select and alignment check (purely combinational).
// Ports: redirect pulses/targets, pending redirect, pc_plus4 in;
//        live pulse select, chosen next PC and misaligned flag out.
module next_pc_mux
   import fetch_pc_unit_pkg::*;
(
   input  logic                jump_reg,
   input  logic [PC_WIDTH-1:0] jump_reg_target,
   input  logic                jump,
   input  logic [PC_WIDTH-1:0] jump_target,
   input  logic                branch_taken,
   input  logic [PC_WIDTH-1:0] branch_target,
   input  logic                pend_valid,
   input  logic [PC_WIDTH-1:0] pend_target,
   input  logic [PC_WIDTH-1:0] pc_plus4,
   output logic                live_valid,
   output logic [PC_WIDTH-1:0] live_target,
   output logic [PC_WIDTH-1:0] next_pc,
   output logic                misaligned
);

   // Several pulses may be high together, so this must be priority.
   always_comb begin
      live_valid  = jump_reg | jump | branch_taken;
      live_target = '0;
      priority case (1'b1)
         jump_reg:     live_target = jump_reg_target;
         jump:         live_target = jump_target;
         branch_taken: live_target = branch_target;
         default:      live_target = '0;
      endcase
   end

   // A live pulse beats the pending redirect, which beats sequential flow.
   always_comb begin
      next_pc = pc_plus4;
      if (live_valid) begin
         next_pc = live_target;
      end else if (pend_valid) begin
         next_pc = pend_target;
      end
      misaligned = !is_word_aligned(next_pc);
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC unit: PC register, fetch FSM and pending-redirect capture.
// Ports: clk/reset, stall, branch/jump/jumpReg redirects, imem bus, PC outs, alignFault.
module fetch_pc_unit
   import fetch_pc_unit_pkg::*;
#(
   parameter logic [PC_WIDTH-1:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                stall,
   input  logic                branchTaken,
   input  logic [PC_WIDTH-1:0] branchTarget,
   input  logic                jump,
   input  logic [PC_WIDTH-1:0] jumpTarget,
   input  logic                jumpReg,
   input  logic [PC_WIDTH-1:0] jumpRegTarget,
   fetch_pc_unit_if.master     imem,
   output logic [PC_WIDTH-1:0] salidaPC,
   output logic [PC_WIDTH-1:0] pcPlus4,
   output logic                instrValid,
   output logic                alignFault
);

   fetch_state_e        state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic                pend_valid_q, pend_valid_d;
   logic [PC_WIDTH-1:0] pend_target_q, pend_target_d;
   logic                align_fault_q, align_fault_d;

   logic                accept;
   logic                live_valid;
   logic [PC_WIDTH-1:0] live_target;
   logic [PC_WIDTH-1:0] next_pc;
   logic                misaligned;

   assign pcPlus4  = pc_q + 32'd4;
   assign salidaPC = pc_q;

   assign imem.imemAddr = pc_q;
   assign imem.imemReq  = (state_q == ST_FETCH);

   assign accept     = imem.imemReq & imem.imemReady & ~stall;
   assign instrValid = accept;
   assign alignFault = align_fault_q;

   next_pc_mux u_mux (
      .jump_reg        (jumpReg),
      .jump_reg_target (jumpRegTarget),
      .jump            (jump),
      .jump_target     (jumpTarget),
      .branch_taken    (branchTaken),
      .branch_target   (branchTarget),
      .pend_valid      (pend_valid_q),
      .pend_target     (pend_target_q),
      .pc_plus4        (pcPlus4),
      .live_valid      (live_valid),
      .live_target     (live_target),
      .next_pc         (next_pc),
      .misaligned      (misaligned)
   );

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      pend_valid_d  = pend_valid_q;
      pend_target_d = pend_target_q;
      align_fault_d = align_fault_q;

      unique case (state_q)
         ST_IDLE: begin
            state_d = ST_FETCH;
            if (live_valid) begin
               pend_valid_d  = 1'b1;
               pend_target_d = live_target;
            end
         end
         ST_FETCH: begin
            if (accept) begin
               // Any accepted redirect (live or pending) is spent here.
               pend_valid_d = 1'b0;
               if (misaligned) begin
                  state_d       = ST_HALT;
                  align_fault_d = 1'b1;
               end else begin
                  pc_d = next_pc;
               end
            end else if (live_valid) begin
               pend_valid_d  = 1'b1;
               pend_target_d = live_target;
            end
         end
         ST_HALT: begin
            state_d = ST_HALT;
         end
         default: begin
            state_d = ST_HALT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         pc_q          <= RESET_VECTOR;
         pend_valid_q  <= 1'b0;
         pend_target_q <= '0;
         align_fault_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         pend_valid_q  <= pend_valid_d;
         pend_target_q <= pend_target_d;
         align_fault_q <= align_fault_d;
      end
   end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed table-driven bench for fetch_pc_unit.
// Second instance covers the wrapping reset vector.
module tb_fetch_pc_unit;
   import fetch_pc_unit_pkg::*;

   logic        clk;
   logic        reset, stall;
   logic        branchTaken, jump, jumpReg;
   logic [31:0] branchTarget, jumpTarget, jumpRegTarget;
   logic [31:0] salidaPC, pcPlus4;
   logic        instrValid, alignFault;

   logic        reset2;
   logic [31:0] salidaPC2, pcPlus4_2;
   logic        instrValid2, alignFault2;

   int n_total = 0;
   int n_pass  = 0;

   fetch_pc_unit_if bus ();
   fetch_pc_unit_if bus2 ();

   fetch_pc_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .branchTaken   (branchTaken),
      .branchTarget  (branchTarget),
      .jump          (jump),
      .jumpTarget    (jumpTarget),
      .jumpReg       (jumpReg),
      .jumpRegTarget (jumpRegTarget),
      .imem          (bus.master),
      .salidaPC      (salidaPC),
      .pcPlus4       (pcPlus4),
      .instrValid    (instrValid),
      .alignFault    (alignFault)
   );

   fetch_pc_unit #(.RESET_VECTOR(32'hFFFF_FFFC)) dut2 (
      .clk           (clk),
      .reset         (reset2),
      .stall         (1'b0),
      .branchTaken   (1'b0),
      .branchTarget  (32'h0),
      .jump          (1'b0),
      .jumpTarget    (32'h0),
      .jumpReg       (1'b0),
      .jumpRegTarget (32'h0),
      .imem          (bus2.master),
      .salidaPC      (salidaPC2),
      .pcPlus4       (pcPlus4_2),
      .instrValid    (instrValid2),
      .alignFault    (alignFault2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst, stl, rdy;
      logic        br;
      logic [31:0] brt;
      logic        j;
      logic [31:0] jt;
      logic        jr;
      logic [31:0] jrt;
      logic        chk;
      logic [31:0] addr;
      logic        req, vld, flt;
   } vec_t;

   vec_t v[$];

   task automatic add(
      input logic rst, stl, rdy,
      input logic br, input logic [31:0] brt,
      input logic j, input logic [31:0] jt,
      input logic jr, input logic [31:0] jrt,
      input logic chk, input logic [31:0] addr,
      input logic req, vld, flt);
      vec_t e;
      e.rst = rst; e.stl = stl; e.rdy = rdy;
      e.br = br; e.brt = brt;
      e.j = j; e.jt = jt;
      e.jr = jr; e.jrt = jrt;
      e.chk = chk; e.addr = addr;
      e.req = req; e.vld = vld; e.flt = flt;
      v.push_back(e);
   endtask

   task automatic seq(input logic rdy, input logic stl,
                      input logic [31:0] addr,
                      input logic req, vld, flt);
      add(0, stl, rdy, 0, 0, 0, 0, 0, 0, 1, addr, req, vld, flt);
   endtask

   task automatic check(input string name, input int idx,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s row %0d: got %h expected %h",
                  name, idx, act, exp);
      else
         n_pass++;
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0;
      branchTaken = 1'b0; branchTarget = '0;
      jump = 1'b0; jumpTarget = '0;
      jumpReg = 1'b0; jumpRegTarget = '0;
      bus.imemReady = 1'b0;
      reset2 = 1'b1;
      bus2.imemReady = 1'b0;

      // reset
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
      add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0);
      // idle, then sequential fetch
      seq(1, 0, 32'h0,  0, 0, 0);
      seq(1, 0, 32'h0,  1, 1, 0);
      seq(1, 0, 32'h4,  1, 1, 0);
      seq(1, 0, 32'h8,  1, 1, 0);
      seq(1, 0, 32'hC,  1, 1, 0);
      // jump beats branch in the same accepting cycle
      add(0, 0, 1, 1, 32'h20, 1, 32'h0040_0000, 0, 0,
          1, 32'h10, 1, 1, 0);
      seq(1, 0, 32'h0040_0000, 1, 1, 0);
      // branch while not ready -> pending
      add(0, 0, 0, 1, 32'h100, 0, 0, 0, 0,
          1, 32'h0040_0004, 1, 0, 0);
      seq(0, 0, 32'h0040_0004, 1, 0, 0);
      seq(0, 0, 32'h0040_0004, 1, 0, 0);
      seq(0, 0, 32'h0040_0004, 1, 0, 0);
      seq(1, 0, 32'h0040_0004, 1, 1, 0);
      seq(1, 0, 32'h100, 1, 1, 0);
      seq(1, 0, 32'h104, 1, 1, 0);
      // stall five cycles
      for (int k = 0; k < 5; k++)
         seq(1, 1, 32'h108, 1, 0, 0);
      seq(1, 0, 32'h108, 1, 1, 0);
      // pending jump overridden by live branch
      add(0, 0, 0, 0, 0, 1, 32'h200, 0, 0,
          1, 32'h10C, 1, 0, 0);
      add(0, 0, 1, 1, 32'h300, 0, 0, 0, 0,
          1, 32'h10C, 1, 1, 0);
      seq(1, 0, 32'h300, 1, 1, 0);
      // misaligned jumpReg -> HALT
      add(0, 0, 1, 0, 0, 0, 0, 1, 32'h0000_0102,
          1, 32'h304, 1, 1, 0);
      seq(1, 0, 32'h304, 0, 0, 1);
      add(0, 0, 1, 1, 32'h400, 0, 0, 0, 0,
          1, 32'h304, 0, 0, 1);
      seq(1, 0, 32'h304, 0, 0, 1);
      // reset beats a redirect, then pulse in IDLE is kept
      add(1, 0, 1, 0, 0, 1, 32'h600, 0, 0,
          1, 32'h304, 0, 0, 1);
      add(0, 0, 0, 0, 0, 1, 32'h500, 0, 0,
          1, 32'h0, 0, 0, 0);
      seq(1, 0, 32'h0,   1, 1, 0);
      seq(1, 0, 32'h500, 1, 1, 0);
      seq(1, 0, 32'h504, 1, 1, 0);
      // reset mid-handshake
      add(1, 0, 0, 0, 0, 0, 0, 0, 0,
          1, 32'h508, 1, 0, 0);
      seq(0, 0, 32'h0, 0, 0, 0);

      foreach (v[i]) begin
         @(negedge clk);
         reset         = v[i].rst;
         stall         = v[i].stl;
         bus.imemReady = v[i].rdy;
         branchTaken   = v[i].br;
         branchTarget  = v[i].brt;
         jump          = v[i].j;
         jumpTarget    = v[i].jt;
         jumpReg       = v[i].jr;
         jumpRegTarget = v[i].jrt;
         #1;
         if (v[i].chk) begin
            check("imemAddr",   i, bus.imemAddr, v[i].addr);
            check("salidaPC",   i, salidaPC, v[i].addr);
            check("pcPlus4",    i, pcPlus4, v[i].addr + 32'd4);
            check("imemReq",    i, 32'(bus.imemReq), 32'(v[i].req));
            check("instrValid", i, 32'(instrValid), 32'(v[i].vld));
            check("alignFault", i, 32'(alignFault), 32'(v[i].flt));
         end
      end

      // wrapping reset vector
      @(negedge clk);
      reset2 = 1'b1;
      @(negedge clk);
      check("wrap_rst_pc",  0, salidaPC2, 32'hFFFF_FFFC);
      check("wrap_rst_p4",  0, pcPlus4_2, 32'h0000_0000);
      check("wrap_rst_req", 0, 32'(bus2.imemReq), 32'd0);
      reset2 = 1'b0;
      bus2.imemReady = 1'b1;
      @(negedge clk);
      check("wrap_req",  1, 32'(bus2.imemReq), 32'd1);
      check("wrap_vld",  1, 32'(instrValid2), 32'd1);
      check("wrap_addr", 1, bus2.imemAddr, 32'hFFFF_FFFC);
      @(negedge clk);
      check("wrap_addr", 2, bus2.imemAddr, 32'h0000_0000);
      check("wrap_flt",  2, 32'(alignFault2), 32'd0);
      check("wrap_req",  2, 32'(bus2.imemReq), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
